// File: rtl/ising_spin_update.sv
// ising_spin_update: sequential sign-threshold spin update for the recurrent
// Ising sampler. Latches one local-field vector, decides one spin per cycle
// into a shadow vector, then publishes the whole vector at once so the
// multiply stage never sees a half-updated mask.
// Build option: define ISING_NOISE_EN to add 16-bit Galois LFSR noise to each
// field before thresholding; without it the update is a deterministic sign
// function and the seed ports are unused.
module ising_spin_update #(
  parameter int          N           = 2,
  parameter int          DATABITS    = 32,
  parameter int          NOISE_SHIFT = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [N-1:0] INIT_SPINS = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  field_valid,
  input  logic [DATABITS*N-1:0] field_in,
  output logic                  field_ready,
  input  logic                  seed_load,
  input  logic [15:0]           seed_in,
  output logic [N-1:0]          spins_out,
  output logic                  spins_valid,
  output logic                  busy,
  output logic [15:0]           iter_count
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int SUMW = DATABITS + 1;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                      state, state_nxt;
  logic [IDXW-1:0]             idx;
  logic [DATABITS*N-1:0]       field_buf;
  logic [N-1:0]                shadow, shadow_nxt;
  logic signed [DATABITS-1:0]  field_cur;
  logic signed [SUMW-1:0]      noise, sum;
  logic                        accept, last;

  // Sign threshold; an exactly-zero sum leaves the spin where it was.
  function automatic logic spin_decide(input logic signed [SUMW-1:0] s,
                                       input logic prev);
    if (s == '0) return prev;
    return ~s[SUMW-1];
  endfunction

  assign accept    = (state == IDLE) && field_valid;
  assign last      = (idx == IDXW'(N - 1));
  assign field_cur = field_buf[idx*DATABITS +: DATABITS];
  // One extra bit of headroom: a 16-bit noise term cannot overflow the sum.
  assign sum       = SUMW'(field_cur) + noise;

`ifdef ISING_NOISE_EN
  logic [15:0] lfsr, lfsr_step;

  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign noise     = SUMW'($signed(lfsr)) <<< NOISE_SHIFT;

  // LFSR: seed loads only while idle (zero seed would lock up, so fall back),
  // otherwise one step per spin decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if ((state == IDLE) && seed_load) begin
      lfsr <= (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
    end else if (state == UPDATE) begin
      lfsr <= lfsr_step;
    end
  end
`else
  logic unused_seed;

  assign noise       = '0;
  assign unused_seed = ^{seed_load, seed_in};
`endif

  // Shadow vector with the current spin's decision merged in.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = spin_decide(sum, shadow[idx]);
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt   = state;
    field_ready = 1'b0;
    busy        = 1'b0;
    spins_valid = 1'b0;
    case (state)
      IDLE: begin
        field_ready = 1'b1;
        if (field_valid) state_nxt = UPDATE;
      end
      UPDATE: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        spins_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Field vector is pure data: captured on handshake, never reset.
  always_ff @(posedge clk) begin
    if (accept) field_buf <= field_in;
  end

  // Control state, spin index, shadow/published spins and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= INIT_SPINS;
      spins_out  <= INIT_SPINS;
      iter_count <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx <= '0;
      end else if (state == UPDATE) begin
        shadow <= shadow_nxt;
        idx    <= last ? '0 : idx + IDXW'(1);
        // Publish together with the last decision so spins_out is already
        // current during the DONE pulse.
        if (last) spins_out <= shadow_nxt;
      end
      if (state == DONE) iter_count <= iter_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_ising_spin_update.sv
// Scoreboard bench for ising_spin_update (N=2). A software model computes the
// expected spin vector whenever a field vector is handed over; the monitor
// pops and compares on every spins_valid pulse.
module tb_ising_spin_update;

  localparam int          N        = 2;
  localparam int          DATABITS = 32;
  localparam int          SUMW     = DATABITS + 1;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [N-1:0] INIT    = 2'b00;
`ifdef ISING_NOISE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  field_valid = 1'b0;
  logic [DATABITS*N-1:0] field_in = '0;
  logic                  seed_load = 1'b0;
  logic [15:0]           seed_in = 16'h0000;
  logic                  field_ready;
  logic [N-1:0]          spins_out;
  logic                  spins_valid;
  logic                  busy;
  logic [15:0]           iter_count;

  always #5 clk = ~clk;

  ising_spin_update #(
    .N(N), .DATABITS(DATABITS), .NOISE_SHIFT(0), .LFSR_SEED(SEED), .INIT_SPINS(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .field_valid(field_valid), .field_in(field_in),
    .field_ready(field_ready), .seed_load(seed_load), .seed_in(seed_in),
    .spins_out(spins_out), .spins_valid(spins_valid), .busy(busy),
    .iter_count(iter_count)
  );

  typedef struct {
    logic [N-1:0] spins;
    logic [15:0]  iter;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  logic [15:0]  m_lfsr = SEED;
  logic [N-1:0] m_spins = INIT;
  logic [15:0]  m_iter = 16'h0000;
  logic         prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = {1'b0, x[15:1]};
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic signed [SUMW-1:0] model_noise(input logic [15:0] x);
    logic signed [15:0] sx;
    sx = $signed(x);
    return NOISE_ON ? SUMW'(sx) : '0;
  endfunction

  function automatic logic [DATABITS*N-1:0] pk(input logic [31:0] f0, input logic [31:0] f1);
    return {f1, f0};
  endfunction

  // Reference sweep: spin k sees the LFSR state after k steps.
  task automatic model_sweep(input logic [DATABITS*N-1:0] f);
    logic signed [DATABITS-1:0] fk;
    logic signed [SUMW-1:0]     s;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      fk = f[k*DATABITS +: DATABITS];
      s  = SUMW'(fk) + model_noise(m_lfsr);
      if (s > 0) m_spins[k] = 1'b1;
      else if (s < 0) m_spins[k] = 1'b0;
      m_lfsr = lfsr_next(m_lfsr);
    end
    e.spins = m_spins;
    e.iter  = m_iter;
    q.push_back(e);
    m_iter = m_iter + 16'h0001;
  endtask

  // Monitor: one comparison set per spins_valid pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (spins_valid) begin
        chk("valid_width", prev_valid, 1'b0);
        chk("queue_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("spins", spins_out, mon_e.spins);
          chk("iter_at_valid", iter_count, mon_e.iter);
        end
      end
      prev_valid <= spins_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!field_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", field_ready, 1'b1);
  endtask

  task automatic send(input logic [DATABITS*N-1:0] f, input logic sl, input logic [15:0] sd);
    wait_ready();
    field_valid = 1'b1;
    field_in    = f;
    seed_load   = sl;
    seed_in     = sd;
    if (sl) m_lfsr = (sd == 16'h0000) ? SEED : sd;
    model_sweep(f);
    @(posedge clk);
    #1;
    field_valid = 1'b0;
    seed_load   = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] sd);
    wait_ready();
    seed_load = 1'b1;
    seed_in   = sd;
    m_lfsr    = (sd == 16'h0000) ? SEED : sd;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_s;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_spins", spins_out, INIT);
    chk("rst_valid", spins_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_iter", iter_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", field_ready, 1'b1);

    // Basic sweep with cycle-exact latency
    send(pk(32'd5, -32'sd3), 1'b0, 16'h0000);
    exp_s = NOISE_ON ? m_spins : 2'b01;
    @(negedge clk);
    chk("t1_ready", field_ready, 1'b0);
    chk("t1_valid", spins_valid, 1'b0);
    chk("t1_busy", busy, 1'b1);
    @(negedge clk);
    chk("t2_ready", field_ready, 1'b0);
    chk("t2_valid", spins_valid, 1'b0);
    @(negedge clk);
    chk("t3_ready", field_ready, 1'b0);
    chk("t3_valid", spins_valid, 1'b1);
    chk("t3_spins", spins_out, exp_s);
    @(negedge clk);
    chk("t4_ready", field_ready, 1'b1);
    chk("t4_valid", spins_valid, 1'b0);
    chk("t4_iter", iter_count, 1);
    chk("t4_busy", busy, 1'b0);

    // Zero field holds, negative clears
    send(pk(32'd1, 32'd1), 1'b0, 16'h0000);
    wait_drain();
    send(pk(32'd0, -32'sd1), 1'b0, 16'h0000);
    wait_drain();
    exp_s = NOISE_ON ? m_spins : 2'b01;
    chk("zero_hold", spins_out, exp_s);

    // Extreme fields never wrap
    for (int i = 0; i < 100; i++) send(pk(32'h7FFFFFFF, 32'h7FFFFFFF), 1'b0, 16'h0000);
    wait_drain();
    chk("max_field", spins_out, 2'b11);
    for (int i = 0; i < 100; i++) send(pk(32'h80000000, 32'h80000000), 1'b0, 16'h0000);
    wait_drain();
    chk("min_field", spins_out, 2'b00);

    // field_valid held through a sweep: second capture only at T+N+2
    wait_ready();
    field_valid = 1'b1;
    field_in    = pk(-32'sd2, 32'd9);
    model_sweep(pk(-32'sd2, 32'd9));
    @(posedge clk);
    #1;
    field_in = pk(32'd3, 32'd3);
    model_sweep(pk(32'd3, 32'd3));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_ready_back", field_ready, 1'b1);
    @(posedge clk);
    #1;
    field_valid = 1'b0;
    wait_drain();
    chk("hold_iter", iter_count, m_iter);

    // Reset in the middle of a sweep (idx=1)
    send(pk(32'd4, 32'd4), 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_spins", spins_out, INIT);
    chk("midrst_valid", spins_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_iter", iter_count, 0);
    q.delete();
    m_spins = INIT;
    m_lfsr  = SEED;
    m_iter  = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    send(pk(-32'sd4, 32'd6), 1'b0, 16'h0000);
    wait_drain();
    chk("post_rst_spins", spins_out, NOISE_ON ? m_spins : 2'b10);
    chk("post_rst_iter", iter_count, 1);

    // Seed handling: zero seed falls back, explicit seed, seed with handshake
    load_seed(16'h0000);
    for (int i = 0; i < 8; i++) send(pk(32'd0, 32'd0), 1'b0, 16'h0000);
    load_seed(16'h0001);
    for (int i = 0; i < 8; i++) send(pk(32'd0, 32'd0), 1'b0, 16'h0000);
    send(pk(32'd100, -32'sd100), 1'b1, 16'h1234);
    // seed_load while busy must be ignored
    seed_load = 1'b1;
    seed_in   = 16'h0005;
    repeat (2) @(posedge clk);
    #1;
    seed_load = 1'b0;
    for (int i = 0; i < 6; i++) send(pk(32'd7, -32'sd7), 1'b0, 16'h0000);
    wait_drain();
    chk("final_iter", iter_count, m_iter);
    chk("final_queue", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ising_spin_update.md
Name: ising_spin_update

Overview:
Downstream stage of the weight-matrix / spin-vector multiply block in the recurrent Ising sampler. It consumes the N local fields (one signed DATABITS word per spin row) and decides the next spin state one spin per cycle: field plus optional LFSR noise, then sign threshold. Its spin vector feeds back as the multiply stage's per-column mask bits, closing the recurrence. It counts completed sweeps.

Parameters:
N, 2, number of spins; equals multiply-stage matrix height.
DATABITS, 32, width of each signed local field.
NOISE_SHIFT, 0, left arithmetic shift applied to the 16-bit noise sample.
LFSR_SEED, 16'hACE1, reset/fallback LFSR state; must be non-zero.
INIT_SPINS, 0, N-bit spin vector loaded at reset.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
field_valid  in  1  field_in holds a complete field vector.
field_in  in  DATABITS*N  signed fields; field k at [k*DATABITS +: DATABITS].
field_ready  out  1  block can accept a vector (high only in IDLE).
seed_load  in  1  load seed_in into LFSR (honoured in IDLE only).
seed_in  in  16  new LFSR seed.
spins_out  out  N  current spin vector; bit k = spin k (1 = up); feeds multiply-stage mask.
spins_valid  out  1  one-cycle pulse when spins_out updates.
busy  out  1  high in UPDATE and DONE.
iter_count  out  16  completed sweeps, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, spins_out=INIT_SPINS, shadow=INIT_SPINS, spins_valid=0, busy=0, iter_count=0, idx=0, LFSR=LFSR_SEED. field_ready=1 when out of reset. Reset mid-sweep aborts the sweep; no partial spins reach spins_out.
- FSM IDLE -> UPDATE -> DONE -> IDLE.
- IDLE: field_ready=1. field_valid=1 registers field_in into an internal buffer, sets idx=0, goes to UPDATE. field_valid during UPDATE/DONE is ignored; it is not queued.
- UPDATE: one spin per cycle. sum = sext(field[idx], DATABITS+1) + noise, in DATABITS+1 bits (cannot overflow). shadow[idx] = 1 if sum>0, 0 if sum<0, unchanged if sum==0. LFSR advances one step per UPDATE cycle. idx==N-1 -> DONE, else idx+1.
- DONE: spins_out<=shadow, spins_valid=1 for this cycle only, iter_count+1, go to IDLE.
- Latency: handshake at edge T; spins_valid high in cycle T+N+1; next vector accepted from T+N+2. Throughput: one sweep per N+2 cycles.
- Spins update sequentially into shadow; spins_out changes only in DONE, so the multiply stage always sees a consistent vector.
- LFSR: 16-bit Galois, right shift, feedback mask 16'hB400. In IDLE, seed_load=1 loads seed_in. seed_in==0 loads LFSR_SEED instead (lock-up guard). seed_load together with an accepted field_valid: both happen, and the first UPDATE uses the loaded seed. seed_load outside IDLE is ignored.
- noise = sext($signed(lfsr), DATABITS+1) <<< NOISE_SHIFT, truncated to DATABITS+1 bits.

Optional Feature:
ISING_NOISE_EN: when defined, noise is the LFSR term above (stochastic sampling). When undefined, noise=0: deterministic sign update, LFSR logic removed, seed_load/seed_in unused. Ports stay the same either way.

Test Plan:
- No noise, N=2, INIT_SPINS=0: field {k0=+5, k1=-3} valid at T -> spins_out=2'b01, spins_valid pulse at T+3 only, iter_count=1, field_ready low T+1..T+3.
- No noise, spins=2'b11, field {0, -1} -> spins_out=2'b01 (zero field holds spin 1, negative clears spin 0).
- Field 32'h7FFFFFFF with noise, NOISE_SHIFT=0, over 100 sweeps -> spin always 1 (no wrap). Field 32'h80000000 -> spin always 0.
- Second field_valid held during UPDATE -> not captured; capture happens at T+N+2; iter_count increments exactly once per sweep.
- rst_n pulled low in UPDATE with idx=1 -> all outputs immediately at reset values; no spins_valid; next sweep behaves from INIT_SPINS.
- Noise enabled: seed_load with seed_in=0 -> LFSR=16'hACE1; seed_in=16'h0001, N=4, fields=0 -> spins match a software Galois-0xB400 model over 8 sweeps.
